if_pc_fetch: RTL and testbench

IF_PC_FETCH -- requirements
Module: if_pc_fetch

---
 rtl/riscv_pkg.sv | 23 ++
 rtl/fetch_fifo.sv | 49 ++++
 rtl/if_pc_fetch.sv | 122 ++++++++++++
 tb/tb_if_pc_fetch.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction-fetch slice: reset PC, NOP encoding,
// stall vector layout, fetch FSM states and the fetch-buffer entry format.
package riscv_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] NOP_INST         = 32'h0000_0013;

   localparam int STALL_W  = 6;
   localparam int STALL_IF = 0;
   localparam int STALL_ID = 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      FLUSH = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, inst} pairs between IF and ID.
// Flush empties it in one cycle; DEPTH must be a power of two.
module fetch_fifo
   import riscv_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   push,
   input  fetch_entry_t           push_data,
   input  logic                   pop,
   output fetch_entry_t           head,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);

   fetch_entry_t   mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;

   // NOTE: sequential state is written with non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (!rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage is left unreset; only pointers and count are, and the
   // consumer masks the head with a non-zero count.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/if_pc_fetch.sv
// Instruction fetch stage: PC sequencing, single-outstanding memory requests,
// branch redirect with in-flight discard, and a small buffer feeding ID.
module if_pc_fetch
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter int          BUF_DEPTH = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall,
   input  logic               br_i,
   input  logic [31:0]        br_addr_i,
   output logic               imem_req_o,
   output logic [31:0]        imem_addr_o,
   input  logic               imem_ack_i,
   input  logic [31:0]        imem_data_i,
   output logic [31:0]        pc_o,
   output logic [31:0]        inst_o,
   output logic               inst_valid_o
);

   localparam int CW = $clog2(BUF_DEPTH) + 1;

   fetch_state_t  state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   target, pc_next;
   logic [CW-1:0] count, count_after;
   logic          push, pop, flush, can_issue;
   fetch_entry_t  head, push_entry;
   logic          unused_bits;

   assign unused_bits = ^{stall[STALL_W-1:2], br_addr_i[1:0]};
   assign push_entry  = '{pc: pc_q, inst: imem_data_i};

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         addr_q  <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         addr_q  <= addr_d;
      end
   end

   // NOTE: every signal driven here gets a default first so no latch is inferred.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      addr_d      = addr_q;
      push        = 1'b0;
      flush       = br_i;
      pop         = inst_valid_o && !stall[STALL_ID] && !br_i;
      target      = {br_addr_i[31:2], 2'b00};
      pc_next     = pc_q + 32'd4;
      count_after = count + CW'(1) - CW'(pop);
      can_issue   = !stall[STALL_IF] && (count_after < CW'(BUF_DEPTH));

      unique case (state_q)
         IDLE: begin
            if (br_i) begin
               pc_d = target;
            end else if (!stall[STALL_IF] && (count < CW'(BUF_DEPTH))) begin
               state_d = REQ;
               addr_d  = pc_q;
            end
         end
         REQ: begin
            if (imem_ack_i && br_i) begin
               pc_d    = target;
               addr_d  = target;
               state_d = REQ;
            end else if (imem_ack_i) begin
               push = 1'b1;
               pc_d = pc_next;
               // Slot for the follow-on request is reserved against the post-push count.
               if (can_issue) begin
                  state_d = REQ;
                  addr_d  = pc_next;
               end else begin
                  state_d = IDLE;
               end
            end else if (br_i) begin
               pc_d    = target;
               state_d = FLUSH;
            end
         end
         FLUSH: begin
            if (br_i) pc_d = target;
            if (imem_ack_i) begin
               state_d = REQ;
               addr_d  = br_i ? target : pc_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   fetch_fifo #(
      .DEPTH(BUF_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .head      (head),
      .count     (count)
   );

   // Address is held in REQ/FLUSH; in IDLE it previews the next fetch PC.
   assign imem_req_o   = (state_q != IDLE);
   assign imem_addr_o  = (state_q == IDLE) ? pc_q : addr_q;
   assign inst_valid_o = (count != '0);
   assign pc_o         = inst_valid_o ? head.pc : 32'h0;
   assign inst_o       = inst_valid_o ? head.inst : NOP_INST;

endmodule

// File: tb/tb_if_pc_fetch.sv
// Directed bench for if_pc_fetch: memory responder with programmable latency,
// expected-fetch scoreboard, and a second instance exercising PC wraparound.
module tb_if_pc_fetch;
   import riscv_pkg::*;

   localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rst;
   logic [STALL_W-1:0] stall;
   logic               br_i;
   logic [31:0]        br_addr_i;
   logic               imem_req_o;
   logic [31:0]        imem_addr_o;
   logic               imem_ack_i;
   logic [31:0]        imem_data_i;
   logic [31:0]        pc_o;
   logic [31:0]        inst_o;
   logic               inst_valid_o;

   logic [STALL_W-1:0] w_stall;
   logic               w_br;
   logic [31:0]        w_br_addr;
   logic               w_req;
   logic [31:0]        w_addr;
   logic               w_ack;
   logic [31:0]        w_data;
   logic [31:0]        w_pc;
   logic [31:0]        w_inst;
   logic               w_valid;

   int           checks = 0;
   int           errors = 0;
   int           mem_lat;
   logic         stray_ack;
   logic         drop_next;
   logic [31:0]  exp_addr;
   fetch_entry_t exp_q[$];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hA5C3_0F00;
   endfunction

   assign w_data = mem_word(w_addr);

   if_pc_fetch u_dut (
      .clk          (clk),
      .rst          (rst),
      .stall        (stall),
      .br_i         (br_i),
      .br_addr_i    (br_addr_i),
      .imem_req_o   (imem_req_o),
      .imem_addr_o  (imem_addr_o),
      .imem_ack_i   (imem_ack_i),
      .imem_data_i  (imem_data_i),
      .pc_o         (pc_o),
      .inst_o       (inst_o),
      .inst_valid_o (inst_valid_o)
   );

   if_pc_fetch #(
      .RESET_PC (WRAP_PC)
   ) u_wrap (
      .clk          (clk),
      .rst          (rst),
      .stall        (w_stall),
      .br_i         (w_br),
      .br_addr_i    (w_br_addr),
      .imem_req_o   (w_req),
      .imem_addr_o  (w_addr),
      .imem_ack_i   (w_ack),
      .imem_data_i  (w_data),
      .pc_o         (w_pc),
      .inst_o       (w_inst),
      .inst_valid_o (w_valid)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_req"},   32'(imem_req_o),   32'd0);
      check({tag, "_addr"},  imem_addr_o,       RESET_PC_DEFAULT);
      check({tag, "_pc"},    pc_o,              32'h0);
      check({tag, "_inst"},  inst_o,            NOP_INST);
      check({tag, "_valid"}, 32'(inst_valid_o), 32'd0);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Memory responder and fetch model: acks after mem_lat cycles of request,
   // pushes kept fetches to the scoreboard, tracks branch redirects and flushes.
   initial begin : mem_model
      int          waited;
      logic        p_rst, p_req, p_ack, p_br;
      logic [31:0] p_addr, p_br_addr;
      waited = 0;
      p_rst = 1'b0; p_req = 1'b0; p_ack = 1'b0; p_br = 1'b0;
      p_addr = '0; p_br_addr = '0;
      drop_next = 1'b0;
      exp_addr = RESET_PC_DEFAULT;
      imem_ack_i = 1'b0;
      imem_data_i = '0;
      forever begin
         @(posedge clk);
         #2;
         if (!p_rst) begin
            waited = 0;
            drop_next = 1'b0;
            exp_q.delete();
            exp_addr = RESET_PC_DEFAULT;
         end else begin
            if (p_req && p_ack) begin
               waited = 0;
               if (p_br || drop_next) begin
                  drop_next = 1'b0;
               end else begin
                  check("ack_addr", p_addr, exp_addr);
                  exp_q.push_back('{pc: exp_addr, inst: mem_word(exp_addr)});
                  check("valid_after_ack", 32'(inst_valid_o), 32'd1);
                  exp_addr = exp_addr + 32'd4;
               end
            end
            if (p_br) begin
               exp_q.delete();
               exp_addr = {p_br_addr[31:2], 2'b00};
               if (p_req && !p_ack) drop_next = 1'b1;
            end
         end
         if (rst && imem_req_o) begin
            waited++;
            imem_ack_i = (waited >= mem_lat);
         end else begin
            imem_ack_i = stray_ack;
         end
         imem_data_i = imem_ack_i ? mem_word(imem_addr_o) : 32'h0;
         p_rst = rst;
         p_req = imem_req_o;
         p_ack = imem_ack_i;
         p_addr = imem_addr_o;
         p_br = br_i;
         p_br_addr = br_addr_i;
      end
   end

   // Scoreboard consumer: compares the head each time ID will take it.
   initial begin : sb_consumer
      fetch_entry_t e;
      forever begin
         @(posedge clk);
         #3;
         if (rst && !br_i && inst_valid_o && !stall[STALL_ID]) begin
            check("sb_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("sb_pc", pc_o, e.pc);
               check("sb_inst", inst_o, e.inst);
            end
         end
      end
   end

   initial begin : main
      rst = 1'b0; stall = '0; br_i = 1'b0; br_addr_i = '0;
      stray_ack = 1'b0; mem_lat = 1;
      w_stall = '0; w_br = 1'b0; w_br_addr = '0; w_ack = 1'b1;
      tick(2);
      check_reset("rst0");
      check("rst0_wrap_addr", w_addr, WRAP_PC);

      // Streaming fetch from reset, zero-wait memory
      rst = 1'b1;
      tick(1);
      check("a_req", 32'(imem_req_o), 32'd1);
      check("a_addr0", imem_addr_o, 32'h0);
      check("w_first_addr", w_addr, WRAP_PC);
      tick(1);
      check("a_addr1", imem_addr_o, 32'h4);
      check("a_valid", 32'(inst_valid_o), 32'd1);
      check("a_pc", pc_o, 32'h0);
      check("w_wrap_addr", w_addr, 32'h0);
      check("w_pc", w_pc, WRAP_PC);
      check("w_inst", w_inst, mem_word(WRAP_PC));
      tick(1);
      check("a_addr2", imem_addr_o, 32'h8);
      check("w_pc2", w_pc, 32'h0);
      tick(5);

      // ID stalled: buffer fills to two entries and requests stop at PC 8
      stall = 6'b000010; rst = 1'b0;
      tick(1);
      check_reset("rst1");
      rst = 1'b1;
      tick(3);
      check("b_req", 32'(imem_req_o), 32'd0);
      check("b_addr", imem_addr_o, 32'h8);
      check("b_valid", 32'(inst_valid_o), 32'd1);
      check("b_pc", pc_o, 32'h0);
      check("b_inst", inst_o, mem_word(32'h0));
      tick(2);
      check("b_hold_req", 32'(imem_req_o), 32'd0);
      mem_lat = 4;
      stall = '0;
      tick(1);
      check("b_release_req", 32'(imem_req_o), 32'd0);
      tick(1);
      check("b_resume_req", 32'(imem_req_o), 32'd1);
      check("b_resume_addr", imem_addr_o, 32'h8);

      // Branch while request to 0x8 is outstanding: flush, then 0x100
      br_i = 1'b1; br_addr_i = 32'h100;
      tick(1);
      br_i = 1'b0;
      check("c_valid", 32'(inst_valid_o), 32'd0);
      check("c_req", 32'(imem_req_o), 32'd1);
      check("c_addr", imem_addr_o, 32'h8);
      tick(2);
      check("c_hold_addr", imem_addr_o, 32'h8);
      tick(1);
      check("c_target_addr", imem_addr_o, 32'h100);
      check("c_target_req", 32'(imem_req_o), 32'd1);
      check("c_drop_valid", 32'(inst_valid_o), 32'd0);
      mem_lat = 1;
      tick(3);

      // Branch coincident with ack: no flush cycle, target aligned
      br_i = 1'b1; br_addr_i = 32'h203;
      tick(1);
      br_i = 1'b0;
      check("d_addr", imem_addr_o, 32'h200);
      check("d_req", 32'(imem_req_o), 32'd1);
      check("d_valid", 32'(inst_valid_o), 32'd0);
      tick(1);
      check("d_valid2", 32'(inst_valid_o), 32'd1);
      check("d_pc", pc_o, 32'h200);
      check("d_inst", inst_o, mem_word(32'h200));

      // Reset mid-request, then a stray ack with no request up
      mem_lat = 6;
      tick(2);
      stall = 6'b000001; rst = 1'b0;
      tick(1);
      check_reset("rst2");
      rst = 1'b1; stray_ack = 1'b1;
      tick(2);
      check("e_valid", 32'(inst_valid_o), 32'd0);
      check("e_req", 32'(imem_req_o), 32'd0);
      check("e_addr", imem_addr_o, RESET_PC_DEFAULT);
      stray_ack = 1'b0;

      // Reset while in FLUSH, then restart at the reset PC
      stall = '0;
      tick(1);
      check("f_req", 32'(imem_req_o), 32'd1);
      check("f_addr", imem_addr_o, 32'h0);
      br_i = 1'b1; br_addr_i = 32'h40;
      tick(1);
      br_i = 1'b0;
      check("f_flush_req", 32'(imem_req_o), 32'd1);
      check("f_flush_addr", imem_addr_o, 32'h0);
      rst = 1'b0;
      tick(1);
      check_reset("rst3");
      rst = 1'b1; mem_lat = 3;
      tick(1);
      check("f_restart_req", 32'(imem_req_o), 32'd1);
      check("f_restart_addr", imem_addr_o, 32'h0);

      // IF stall lets the outstanding request finish and buffer its data
      stall = 6'b000001;
      tick(3);
      check("g_req", 32'(imem_req_o), 32'd0);
      check("g_valid", 32'(inst_valid_o), 32'd1);
      check("g_pc", pc_o, 32'h0);
      check("g_addr", imem_addr_o, 32'h4);
      tick(2);
      check("g_hold_req", 32'(imem_req_o), 32'd0);
      stall = '0; mem_lat = 1;
      tick(6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
